hi_lo_mdu: RTL and testbench

- Iterative multiply unit in the EX stage, alongside the ALU.
- Owns the architectural HI/LO registers and drives the ALU's Hi_in/Lo_in operands.
- Executes mult, multu, madd, msub, mthi and mtlo.
- Raises Busy so hazard logic stalls the pipeline until the 64-bit result is committed.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_shift_add_step.sv | 33 +++
 rtl/hi_lo_mdu.sv | 195 +++++++++++++++++++
 tb/tb_hi_lo_mdu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, widths.
// The HI_LO_MDU_DIV_EN build macro adds the DIV state.
package mdu_pkg;

  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDOP_W     = 4;

  localparam logic [MDOP_W-1:0] MDOP_NOP   = 4'b0000;
  localparam logic [MDOP_W-1:0] MDOP_MULT  = 4'b0001;
  localparam logic [MDOP_W-1:0] MDOP_MULTU = 4'b0010;
  localparam logic [MDOP_W-1:0] MDOP_MADD  = 4'b0011;
  localparam logic [MDOP_W-1:0] MDOP_MSUB  = 4'b0100;
  localparam logic [MDOP_W-1:0] MDOP_MTHI  = 4'b0101;
  localparam logic [MDOP_W-1:0] MDOP_MTLO  = 4'b0110;
  localparam logic [MDOP_W-1:0] MDOP_DIV   = 4'b0111;
  localparam logic [MDOP_W-1:0] MDOP_DIVU  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
`ifdef HI_LO_MDU_DIV_EN
    ST_DIV  = 2'd3,
`endif
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Ops whose operands are latched as magnitudes with a separate sign flag
  function automatic logic mdu_is_signed(input logic [MDOP_W-1:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MADD) || (op == MDOP_MSUB) || (op == MDOP_DIV);
  endfunction

endpackage

// File: rtl/mdu_shift_add_step.sv
// One radix-2 iteration on the double-width accumulator: shift-add for multiply,
// and (with HI_LO_MDU_DIV_EN) restoring subtract/shift for divide.
module mdu_shift_add_step #(
  parameter int unsigned W = 32
) (
`ifdef HI_LO_MDU_DIV_EN
  input  logic           div_i,
`endif
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opnd_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0] add_sum;
`ifdef HI_LO_MDU_DIV_EN
  logic [W:0] trial;
`endif

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, LSB consumed first
    add_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    acc_o   = {add_sum, acc_i[W-1:1]};
`ifdef HI_LO_MDU_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}; restore on borrow
    trial = acc_i[2*W-1:W-1] - {1'b0, opnd_i};
    if (div_i) begin
      acc_o = trial[W] ? {acc_i[2*W-2:0], 1'b0}
                       : {trial[W-1:0], acc_i[W-2:0], 1'b1};
    end
`endif
  end

endmodule

// File: rtl/hi_lo_mdu.sv
// EX-stage iterative multiply unit owning the architectural HI/LO registers.
// Define HI_LO_MDU_DIV_EN to add restoring div/divu.
module hi_lo_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W,
  parameter int unsigned ITER   = DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [3:0]        MDOp,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Flush,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CNT_W = $clog2(ITER) + 1;
  localparam int unsigned ACC_W = 2 * DATA_W;

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [MDOP_W-1:0]   op_q, op_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef HI_LO_MDU_DIV_EN
  logic                rneg_q, rneg_d;
  logic                divz_q, divz_d;
  logic [DATA_W-1:0]   quot, rem;
`endif

  logic [DATA_W-1:0]   a_abs, b_abs;
  logic                sgn_op;
  logic [ACC_W-1:0]    step_acc;
  logic [ACC_W-1:0]    prod_s;

  assign sgn_op = mdu_is_signed(MDOp);
  assign a_abs  = (sgn_op && A[DATA_W-1]) ? DATA_W'(-A) : A;
  assign b_abs  = (sgn_op && B[DATA_W-1]) ? DATA_W'(-B) : B;
  assign prod_s = neg_q ? ACC_W'(-acc_q) : acc_q;
`ifdef HI_LO_MDU_DIV_EN
  assign quot   = acc_q[DATA_W-1:0];
  assign rem    = acc_q[ACC_W-1:DATA_W];
`endif

  mdu_shift_add_step #(.W(DATA_W)) u_step (
`ifdef HI_LO_MDU_DIV_EN
    .div_i  (state_q == ST_DIV),
`endif
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef HI_LO_MDU_DIV_EN
    rneg_d  = rneg_q;
    divz_d  = divz_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (Start && !Flush) begin
          case (MDOp)
            MDOP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            MDOP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            MDOP_MULT, MDOP_MULTU, MDOP_MADD, MDOP_MSUB: begin
              acc_d   = {DATA_W'(0), b_abs};
              opnd_d  = a_abs;
              neg_d   = sgn_op & (A[DATA_W-1] ^ B[DATA_W-1]);
              op_d    = MDOp;
              cnt_d   = '0;
              state_d = ST_CALC;
            end
`ifdef HI_LO_MDU_DIV_EN
            MDOP_DIV, MDOP_DIVU: begin
              acc_d   = {DATA_W'(0), a_abs};
              opnd_d  = b_abs;
              neg_d   = sgn_op & (A[DATA_W-1] ^ B[DATA_W-1]);
              rneg_d  = sgn_op & A[DATA_W-1];
              divz_d  = (B == '0);
              op_d    = MDOp;
              cnt_d   = '0;
              state_d = ST_DIV;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
      end
`ifdef HI_LO_MDU_DIV_EN
      ST_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
      end
`endif
      ST_FIX: begin
        case (op_q)
          MDOP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          MDOP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`ifdef HI_LO_MDU_DIV_EN
          MDOP_DIV, MDOP_DIVU: begin
            lo_d = divz_q ? '1 : (neg_q ? DATA_W'(-quot) : quot);
            hi_d = rneg_q ? DATA_W'(-rem) : rem;
          end
`endif
          default:   {hi_d, lo_d} = prod_s;
        endcase
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush aborts any in-flight op, including its commit
    if (Flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_FIX) done_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HI_LO_MDU_DIV_EN
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HI_LO_MDU_DIV_EN
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
`endif
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_hi_lo_mdu.sv
// Randomized self-checking bench for hi_lo_mdu against a 64-bit arithmetic model of HI/LO.
module tb_hi_lo_mdu;

  localparam int unsigned ITER = 32;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = 4'h0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Flush = 1'b0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] hl_m = '0;

  hi_lo_mdu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Flush (Flush),
    .Hi    (Hi),
    .Lo    (Lo),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on {HI,LO}
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hl, output logic [63:0] nhl,
                                output bit multi, output bit mov);
    logic [63:0] sp, up;
    int q, r;
    sp    = 64'(longint'($signed(a)) * longint'($signed(b)));
    up    = {32'h0, a} * {32'h0, b};
    nhl   = hl;
    multi = 1'b0;
    mov   = 1'b0;
    case (op)
      4'h1: begin nhl = sp;      multi = 1'b1; end
      4'h2: begin nhl = up;      multi = 1'b1; end
      4'h3: begin nhl = hl + sp; multi = 1'b1; end
      4'h4: begin nhl = hl - sp; multi = 1'b1; end
      4'h5: begin nhl = {a, hl[31:0]};  mov = 1'b1; end
      4'h6: begin nhl = {hl[63:32], a}; mov = 1'b1; end
`ifdef HI_LO_MDU_DIV_EN
      4'h7: begin
        multi = 1'b1;
        if (b == 32'h0) nhl = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) nhl = {32'h0, 32'h8000_0000};
        else begin
          q = int'($signed(a)) / int'($signed(b));
          r = int'($signed(a)) % int'($signed(b));
          nhl = {32'(r), 32'(q)};
        end
      end
      4'h8: begin
        multi = 1'b1;
        if (b == 32'h0) nhl = {a, 32'hFFFF_FFFF};
        else nhl = {a % b, a / b};
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_hl;
    bit multi, mov;
    int busy_n, done_n;
    model(op, a, b, hl_m, exp_hl, multi, mov);
    MDOp = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = 4'h0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 100; i++) begin
      done_n += int'(Done);
      if (!Busy) break;
      busy_n++;
      @(posedge Clk); #1;
    end
    chk({tag, "_busy_len"}, 64'(busy_n), multi ? 64'(ITER + 1) : 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_n), (multi || mov) ? 64'd1 : 64'd0);
    chk({tag, "_hilo"}, {Hi, Lo}, exp_hl);
    hl_m = exp_hl;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 8) return 4'(r);
    return 4'($urandom_range(9, 15));
  endfunction

  initial begin
    int done_n;
    #2 Reset = 1'b0;
    #20;
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1;

    run_op("mult_m3x7", 4'h1, 32'hFFFF_FFFD, 32'd7);
    chk("mult_m3x7_ref", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu_max", 4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_ref", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mthi0", 4'h5, 32'h0, 32'h0);
    run_op("mtlo1s", 4'h6, 32'hFFFF_FFFF, 32'h0);
    run_op("madd_carry", 4'h3, 32'd1, 32'd1);
    chk("madd_carry_ref", {Hi, Lo}, 64'h0000_0001_0000_0000);
    run_op("msub_borrow", 4'h4, 32'd1, 32'd1);
    chk("msub_borrow_ref", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);

    // Flush 10 cycles into a multiply
    MDOp = 4'h1; A = 32'd5; B = 32'd6; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = 4'h0;
    done_n = int'(Done);
    repeat (9) begin @(posedge Clk); #1; done_n += int'(Done); end
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    chk("flush_busy", 64'(Busy), 64'd0);
    repeat (40) begin done_n += int'(Done); @(posedge Clk); #1; end
    chk("flush_done", 64'(done_n), 64'd0);
    chk("flush_hilo", {Hi, Lo}, hl_m);

    // Flush in IDLE suppresses Start
    MDOp = 4'h5; A = 32'h1234_5678; Start = 1'b1; Flush = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0; MDOp = 4'h0;
    chk("idle_flush_done", 64'(Done), 64'd0);
    chk("idle_flush_hilo", {Hi, Lo}, hl_m);

    // Start while busy is ignored, including mthi
    MDOp = 4'h1; A = 32'd3; B = 32'd4; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    MDOp = 4'h1; A = 32'd100; B = 32'd200; Start = 1'b1;
    @(posedge Clk); #1;
    MDOp = 4'h5; A = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = 4'h0;
    for (int i = 0; i < 100 && Busy; i++) begin @(posedge Clk); #1; end
    hl_m = 64'd12;
    chk("busy_start_hilo", {Hi, Lo}, hl_m);
    repeat (3) begin @(posedge Clk); #1; end
    chk("busy_start_idle", 64'(Busy), 64'd0);

    // Async reset mid-CALC
    MDOp = 4'h1; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = 4'h0;
    repeat (5) begin @(posedge Clk); #1; end
    Reset = 1'b0;
    #1;
    chk("midrst_hilo", {Hi, Lo}, 64'd0);
    chk("midrst_busy", 64'(Busy), 64'd0);
    hl_m = '0;
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1;

    run_op("div_m7_2", 4'h7, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_7_0", 4'h8, 32'd7, 32'd0);
    run_op("div_min_m1", 4'h7, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_0", 4'h7, 32'hFFFF_FFF0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = rand_op();
      a  = rand_opnd();
      b  = rand_opnd();
      run_op($sformatf("rnd%0d_op%0h", n, op), op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
